// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// FSM states, register word offsets, CTRL bit fields and mode codes.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM       = 3;
   localparam int CTRL_W        = 4;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Codes 1x fall back to one-shot behaviour.
   function automatic logic is_reload(input logic [1:0] mode);
      return mode == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// Countdown timer responder on the data-memory path.
// Three word registers (CTRL, PRESET, COUNT) and an IRQ line to CP0.
module timer_dev #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   import timer_pkg::*;

   logic [CTRL_W-1:0] ctrl;
   logic [31:0]       preset;
   logic [31:0]       count;
   state_e            state;
   logic              irq_flag;

   logic [29:0] word_off;
   logic [1:0]  sel;
   logic        hit;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        unused_bits;

   // Out-of-window addresses wrap to large offsets and miss.
   assign word_off = addr[31:2] - BASE_ADDR[31:2];
   assign hit      = word_off < 30'd3;
   assign sel      = word_off[1:0];

   assign wr_ctrl   = we && hit && (sel == OFF_CTRL);
   assign wr_preset = we && hit && (sel == OFF_PRESET);

   assign unused_bits = ^{addr[1:0], wd[31:CTRL_W]};

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         state    <= ST_IDLE;
         irq_flag <= 1'b0;
      end else begin
         if (wr_preset)
            preset <= wd;

         unique case (state)
            ST_IDLE: begin
               if (ctrl[CTRL_EN])
                  state <= ST_LOAD;
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl[CTRL_EN]) begin
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count    <= '0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            ST_INT: begin
               if (is_reload(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB])) begin
                  irq_flag <= 1'b0;
                  state    <= ST_LOAD;
               end else begin
                  ctrl[CTRL_EN] <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Placed last so a CPU write overrides any FSM update.
         if (wr_ctrl) begin
            ctrl     <= wd[CTRL_W-1:0];
            irq_flag <= 1'b0;
         end
      end
   end

   always_comb begin
      rd = '0;
      if (hit) begin
         unique case (1'b1)
            sel == OFF_CTRL:   rd = {{(32-CTRL_W){1'b0}}, ctrl};
            sel == OFF_PRESET: rd = preset;
            sel == OFF_COUNT:  rd = count;
            default:           rd = '0;
         endcase
      end
   end

   assign irq = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus random
// one-shot / reload runs checked against an arithmetic timing model.
module tb_timer_dev;

   localparam logic [31:0] BASE = 32'h0000_7F00;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        irq;

   int n_chk = 0;
   int n_fail = 0;

   timer_dev #(.BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wd    (wd),
      .rd    (rd),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Effective preset: 0 behaves like 1.
   function automatic int eff(input int n);
      return (n == 0) ? 1 : n;
   endfunction

   // COUNT k edges after the enabling CTRL write (count starts at 0).
   function automatic logic [31:0] m_count(input int n, input bit rl,
                                           input int k);
      int m;
      if (k < 2) return 32'd0;
      m = k - 2;
      if (rl) m = m % (eff(n) + 2);
      return (m < eff(n)) ? 32'(n - m) : 32'd0;
   endfunction

   function automatic bit m_flag(input int n, input bit rl, input int k);
      int m;
      if (k < 2) return 1'b0;
      m = k - 2;
      if (!rl) return m >= eff(n);
      return (m % (eff(n) + 2)) == eff(n);
   endfunction

   function automatic logic [31:0] m_ctrl(input logic [3:0] c, input int n,
                                          input int k);
      bit rl;
      rl = (c[2:1] == 2'b01);
      if (!rl && k >= eff(n) + 3) return {28'd0, c & 4'he};
      return {28'd0, c};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wd   = d;
      we   = 1'b1;
      tick();
      we   = 1'b0;
   endtask

   task automatic rchk(input string tag, input logic [31:0] off,
                       input logic [31:0] exp);
      addr = BASE + off;
      #1;
      check(tag, rd, exp);
   endtask

   task automatic regs(input string tag, input logic [31:0] c,
                       input logic [31:0] p, input logic [31:0] n,
                       input logic i);
      rchk({tag, ".ctrl"}, 32'h0, c);
      rchk({tag, ".preset"}, 32'h4, p);
      rchk({tag, ".count"}, 32'h8, n);
      check({tag, ".irq"}, {31'd0, irq}, {31'd0, i});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      we    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // A write that must have no effect: COUNT or outside the window.
   task automatic noise();
      int s;
      s = $urandom_range(0, 3);
      case (s)
         0:       addr = BASE + 32'h8 + $urandom_range(0, 3);
         1:       addr = BASE + 32'hC + $urandom_range(0, 3);
         2:       addr = BASE - 32'h4;
         default: addr = $urandom | 32'h8000_0000;
      endcase
      wd = $urandom;
      we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic run_trial(input string tag, input int n,
                            input logic [3:0] c, input int kmax,
                            input bit noisy);
      bit rl;
      rl = (c[2:1] == 2'b01);
      do_reset();
      wr(BASE + 32'h4 + $urandom_range(0, 3), 32'(n));
      wr(BASE, {28'd0, c});
      regs({tag, ".k0"}, {28'd0, c}, 32'(n), 32'd0, 1'b0);
      for (int k = 1; k <= kmax; k++) begin
         if (noisy) noise();
         else tick();
         regs($sformatf("%s.k%0d", tag, k), m_ctrl(c, n, k), 32'(n),
              m_count(n, rl, k), c[3] & m_flag(n, rl, k));
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      regs("reset", 32'd0, 32'd0, 32'd0, 1'b0);

      // One-shot, PRESET=5: irq after E7, EN cleared from E8
      run_trial("oneshot5", 5, 4'h9, 10, 1'b0);
      wr(BASE, 32'h0);
      regs("oneshot5.clr", 32'd0, 32'd5, 32'd0, 1'b0);

      // Auto-reload, PRESET=3: pulse every 5 cycles
      run_trial("reload3", 3, 4'hB, 18, 1'b0);

      // PRESET=0 behaves as 1
      run_trial("preset0", 0, 4'h9, 6, 1'b0);

      // Disable mid-count: COUNT frozen at 6, no irq
      do_reset();
      wr(BASE + 32'h4, 32'd10);
      wr(BASE, 32'h9);
      for (int k = 1; k <= 5; k++) tick();
      regs("dis.pre", 32'h9, 32'd10, 32'd7, 1'b0);
      wr(BASE, 32'h8);
      for (int k = 0; k < 6; k++)
         regs($sformatf("dis.c%0d", k), 32'h8, 32'd10, 32'd6, 1'b0);
      for (int k = 0; k < 6; k++) tick();
      regs("dis.end", 32'h8, 32'd10, 32'd6, 1'b0);

      // Masked one-shot, then IM=1 without EN keeps irq low
      run_trial("im0", 2, 4'h1, 8, 1'b0);
      wr(BASE, 32'h8);
      regs("im0.unmask", 32'h8, 32'd2, 32'd0, 1'b0);
      tick();
      regs("im0.unmask2", 32'h8, 32'd2, 32'd0, 1'b0);

      // Writes to COUNT and outside the window are ignored
      wr(BASE + 32'hC, 32'hFFFF_FFFF);
      wr(BASE + 32'h8, 32'h1234);
      wr(BASE - 32'h4, 32'h7);
      regs("ign", 32'h8, 32'd2, 32'd0, 1'b0);
      rchk("rd.c", 32'hC, 32'd0);
      rchk("rd.10", 32'h10, 32'd0);

      // Re-enable during the INT cycle of one-shot: CPU write wins
      do_reset();
      wr(BASE + 32'h4, 32'd2);
      wr(BASE, 32'h9);
      for (int k = 1; k <= 4; k++) tick();
      regs("reen.int", 32'h9, 32'd2, 32'd0, 1'b1);
      wr(BASE, 32'h9);
      regs("reen.k0", 32'h9, 32'd2, 32'd0, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         regs($sformatf("reen.k%0d", k), m_ctrl(4'h9, 2, k), 32'd2,
              m_count(2, 1'b0, k), m_flag(2, 1'b0, k));
      end

      // Reset mid-count overrides a simultaneous PRESET write
      do_reset();
      wr(BASE + 32'h4, 32'd20);
      wr(BASE, 32'h9);
      for (int k = 0; k < 4; k++) tick();
      regs("rst.pre", 32'h9, 32'd20, 32'd18, 1'b0);
      addr  = BASE + 32'h4;
      wd    = 32'd123;
      we    = 1'b1;
      reset = 1'b1;
      tick();
      we    = 1'b0;
      reset = 1'b0;
      regs("rst.post", 32'd0, 32'd0, 32'd0, 1'b0);
      for (int k = 0; k < 3; k++) tick();
      regs("rst.idle", 32'd0, 32'd0, 32'd0, 1'b0);

      // Random runs with ignored writes interleaved
      for (int t = 0; t < 8; t++) begin
         int n;
         logic [3:0] c;
         n = $urandom_range(0, 20);
         c = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
         run_trial($sformatf("rnd%0d", t), n, c, 3 * (eff(n) + 2) + 2,
                   1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
